// File: rtl/simd_pkg.sv
// Shared types and defaults for the result store unit: FSM state encoding,
// default matrix size, data word width and default base address.
package simd_pkg;

  localparam int          DEF_N    = 16;
  localparam int          WORD_W   = 32;
  localparam logic [31:0] DEF_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ROW,
    ST_WRITE,
    ST_FINISH
  } store_state_t;

endpackage

// File: rtl/row_buffer.sv
// N x 32-bit row holding register: loads a whole result row in one cycle and
// presents the word selected by the column index.
module row_buffer
  import simd_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CW = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_load,
  input  logic [N-1:0][WORD_W-1:0] i_row,
  input  logic [CW-1:0]          i_col,
  output logic [WORD_W-1:0]      o_word
);

  logic [N-1:0][WORD_W-1:0] r_buf;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_buf <= '0;
    end else if (i_load) begin
      r_buf <= i_row;
    end
  end

  assign o_word = r_buf[i_col];

endmodule

// File: rtl/result_store_unit.sv
// Streams an N x N result matrix, one row at a time, into data memory as
// 32-bit word writes. Optional running checksum under RESULT_STORE_CHECKSUM_EN.
module result_store_unit
  import simd_pkg::*;
#(
  parameter int          N    = DEF_N,
  parameter logic [31:0] ADDR = DEF_ADDR
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_start,
  input  logic                     i_res_valid,
  input  logic [N-1:0][WORD_W-1:0] i_res_row,
  output logic                     o_res_ready,
  output logic                     o_mem_valid,
  output logic [WORD_W-1:0]        o_mem_addr,
  output logic [WORD_W-1:0]        o_mem_wdata,
  input  logic                     i_mem_ready,
  output logic                     o_busy,
  output logic                     o_done
`ifdef RESULT_STORE_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0]        o_checksum
`endif
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  store_state_t        r_state, w_state_nxt;
  logic [CW-1:0]       r_row, r_col;
  logic [WORD_W-1:0]   r_last_addr;
  logic [WORD_W-1:0]   w_addr, w_buf_word;
  logic                w_load, w_clr_all, w_col_inc, w_row_inc;

  row_buffer #(.N(N), .CW(CW)) u_row_buffer (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_load (w_load),
    .i_row  (i_res_row),
    .i_col  (r_col),
    .o_word (w_buf_word)
  );

  // Wraps modulo 2^32 by construction of the 32-bit sum.
  assign w_addr = ADDR + ((32'(r_row) * 32'(N) + 32'(r_col)) << 2);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clr_all   = 1'b0;
    w_col_inc   = 1'b0;
    w_row_inc   = 1'b0;
    o_res_ready = 1'b0;
    o_mem_valid = 1'b0;
    o_mem_wdata = '0;
    o_mem_addr  = r_last_addr;
    o_done      = 1'b0;
    o_busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_clr_all   = 1'b1;
          w_state_nxt = ST_WAIT_ROW;
        end
      end
      ST_WAIT_ROW: begin
        o_res_ready = 1'b1;
        if (i_res_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        o_mem_valid = 1'b1;
        o_mem_wdata = w_buf_word;
        o_mem_addr  = w_addr;
        if (i_mem_ready) begin
          if (r_col != LAST) begin
            w_col_inc = 1'b1;
          end else if (r_row != LAST) begin
            w_row_inc   = 1'b1;
            w_state_nxt = ST_WAIT_ROW;
          end else begin
            w_state_nxt = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_row       <= '0;
      r_col       <= '0;
      r_last_addr <= ADDR;
    end else begin
      if (w_clr_all) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_load) begin
        r_col <= '0;
      end else if (w_col_inc) begin
        r_col <= r_col + 1'b1;
      end else if (w_row_inc) begin
        r_row <= r_row + 1'b1;
      end
      // Address output keeps showing the last presented word outside WRITE.
      if (r_state == ST_WRITE) begin
        r_last_addr <= w_addr;
      end
    end
  end

`ifdef RESULT_STORE_CHECKSUM_EN
  logic [WORD_W-1:0] r_checksum;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_checksum <= '0;
    end else if (w_clr_all) begin
      r_checksum <= '0;
    end else if (o_mem_valid && i_mem_ready) begin
      r_checksum <= r_checksum + o_mem_wdata;
    end
  end

  assign o_checksum = r_checksum;
`endif

endmodule

// File: tb/tb_result_store_unit.sv
// Randomized bench for result_store_unit against a word-count reference model.
module tb_result_store_unit;

  localparam int          N    = 16;
  localparam logic [31:0] ADDR = 32'h0000_0000;

  logic                 clk;
  logic                 rstn;
  logic                 i_start;
  logic                 i_res_valid;
  logic [N-1:0][31:0]   i_res_row;
  logic                 o_res_ready;
  logic                 o_mem_valid;
  logic [31:0]          o_mem_addr;
  logic [31:0]          o_mem_wdata;
  logic                 i_mem_ready;
  logic                 o_busy;
  logic                 o_done;
`ifdef RESULT_STORE_CHECKSUM_EN
  logic [31:0]          o_checksum;
`endif

  result_store_unit #(.N(N), .ADDR(ADDR)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_start     (i_start),
    .i_res_valid (i_res_valid),
    .i_res_row   (i_res_row),
    .o_res_ready (o_res_ready),
    .o_mem_valid (o_mem_valid),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ready (i_mem_ready),
    .o_busy      (o_busy),
    .o_done      (o_done)
`ifdef RESULT_STORE_CHECKSUM_EN
    ,
    .o_checksum  (o_checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: a transfer is "rows accepted" and "words accepted" counts.
  logic [31:0] mat [N][N];
  bit          m_on, m_fin;
  int          m_rows, m_words;
  logic [31:0] m_last, m_sum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit f_rdy();
    return m_on && (m_words == m_rows * N) && (m_rows < N);
  endfunction

  function automatic bit f_mv();
    return m_on && (m_words < m_rows * N);
  endfunction

  function automatic logic [31:0] f_addr();
    return f_mv() ? ADDR + 32'(m_words * 4) : m_last;
  endfunction

  function automatic logic [31:0] f_data();
    return f_mv() ? mat[m_words / N][m_words % N] : 32'h0;
  endfunction

  task automatic model_reset();
    m_on = 0; m_fin = 0; m_rows = 0; m_words = 0; m_last = ADDR; m_sum = 0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_res_ready"}, {31'b0, o_res_ready}, 32'h0);
    chk({pfx, "_mem_valid"}, {31'b0, o_mem_valid}, 32'h0);
    chk({pfx, "_mem_addr"},  o_mem_addr, ADDR);
    chk({pfx, "_mem_wdata"}, o_mem_wdata, 32'h0);
    chk({pfx, "_busy"},      {31'b0, o_busy}, 32'h0);
    chk({pfx, "_done"},      {31'b0, o_done}, 32'h0);
`ifdef RESULT_STORE_CHECKSUM_EN
    chk({pfx, "_checksum"},  o_checksum, 32'h0);
`endif
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic do_cycle(input bit st, input bit vl, input bit rd, input bit abort,
                          output bit saw_done);
    bit          e_rdy, e_mv, was_fin;
    logic [31:0] e_addr, e_data;
    e_rdy = f_rdy();
    e_mv  = f_mv();
    e_addr = f_addr();
    e_data = f_data();
    i_start     = st;
    i_res_valid = vl;
    i_mem_ready = rd;
    for (int c = 0; c < N; c++)
      i_res_row[c] = e_rdy ? mat[m_rows][c] : $urandom;
    @(negedge clk);
    chk("res_ready", {31'b0, o_res_ready}, {31'b0, e_rdy});
    chk("mem_valid", {31'b0, o_mem_valid}, {31'b0, e_mv});
    chk("mem_addr",  o_mem_addr, e_addr);
    chk("mem_wdata", o_mem_wdata, e_data);
    chk("busy",      {31'b0, o_busy}, {31'b0, (m_on || m_fin)});
    chk("done",      {31'b0, o_done}, {31'b0, m_fin});
`ifdef RESULT_STORE_CHECKSUM_EN
    if (m_fin) chk("checksum", o_checksum, m_sum);
`endif
    saw_done = o_done;
    if (abort) begin
      #2;
      rstn = 1'b0;
      #1;
      chk_reset_vals("abort");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      model_reset();
      cyc++;
      return;
    end
    @(posedge clk);
    was_fin = m_fin;
    m_fin = 0;
    if (!m_on && !was_fin && st) begin
      m_on = 1; m_rows = 0; m_words = 0; m_sum = 0;
    end else if (e_rdy && vl) begin
      m_rows++;
    end else if (e_mv && rd) begin
      m_last = e_addr;
      m_sum  = m_sum + e_data;
      m_words++;
      if (m_words == N * N) begin
        m_on  = 0;
        m_fin = 1;
      end
    end
    #1;
    cyc++;
  endtask

  task automatic run_matrix(input int rpct, input int vpct, input int stall_w,
                            input int hold_r, input int abort_w, input bit noise,
                            input bit lat);
    bit dn, ab, st, vl, rd;
    int budget, cs, stall_n, hold_n;
    dn = 0; ab = 0; budget = 0; stall_n = 0; hold_n = 0;
    cs = cyc;
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0, dn);
    while (!dn && !ab && budget < 4000) begin
      vl = (vpct >= 100) ? 1'b1 : ($urandom_range(0, 99) < vpct);
      if (f_rdy() && m_rows == hold_r && hold_n < 5) begin
        vl = 1'b0;
        hold_n++;
      end
      rd = (rpct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rpct);
      if (f_mv() && m_words == stall_w && stall_n < 3) begin
        rd = 1'b0;
        stall_n++;
      end
      st = noise ? ($urandom_range(0, 7) == 0) : 1'b0;
      ab = f_mv() && (m_words == abort_w);
      do_cycle(st, vl, rd, ab, dn);
      budget++;
    end
    if (abort_w >= 0) begin
      chk("abort_reached", {31'b0, ab}, 32'h1);
      chk("abort_no_done", {31'b0, dn}, 32'h0);
    end else begin
      chk("done_seen", {31'b0, dn}, 32'h1);
      if (lat && dn) chk("start_to_done_cycles", 32'(cyc - cs), 32'(N * (N + 1) + 2));
    end
    for (int k = 0; k < 2; k++) do_cycle(1'b0, 1'b0, 1'b0, 1'b0, dn);
  endtask

  task automatic fill_seq();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat[r][c] = 32'(r * N + c + 1);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat[r][c] = $urandom;
  endtask

  initial begin
    bit dn;
    rstn = 1'b0;
    i_start = 1'b0; i_res_valid = 1'b0; i_mem_ready = 1'b0; i_res_row = '0;
    model_reset();
    #3;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0, dn);

    // Sequential data, memory always ready: 256 writes, DONE at the expected cycle.
    fill_seq();
    run_matrix(100, 100, -1, -1, -1, 1'b0, 1'b1);
`ifdef RESULT_STORE_CHECKSUM_EN
    chk("checksum_seq", o_checksum, 32'd32896);
`endif
    // Memory stall on row 2 col 5, and a 5-cycle gap before row 3 arrives.
    run_matrix(100, 100, 2 * N + 5, 3, -1, 1'b0, 1'b0);
    // Random data, random handshakes, stray START and RES_VALID while busy.
    fill_rand();
    run_matrix(70, 60, -1, -1, -1, 1'b1, 1'b0);
    // Reset in the middle of row 7 col 3, then a clean full-speed restart.
    fill_rand();
    run_matrix(80, 100, -1, -1, 7 * N + 3, 1'b1, 1'b0);
    fill_rand();
    run_matrix(100, 100, -1, -1, -1, 1'b0, 1'b1);
    fill_rand();
    run_matrix(50, 50, -1, -1, -1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
